// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit counters, mispredict flush/redirect
//
// Purpose: fetch-side branch predictor. Looks up fetch_pc combinationally to
// produce pred_hit/spec_taken/pred_next_pc. Execute-stage resolution
// (upd_*) trains the table at the next posedge and raises a same-cycle
// flush/redirect_pc on mispredict.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_pc                 PC being fetched
//   pred_hit                 valid entry with matching tag for fetch_pc
//   spec_taken               predicted taken
//   pred_next_pc             predicted next PC
//   upd_valid                execute stage holds a valid instruction
//   upd_is_branch            that instruction is a branch/jump
//   upd_pc                   its PC
//   upd_taken, upd_target    resolved direction and taken target
//   upd_spec_taken           prediction carried down the pipe
//   upd_pred_next            predicted next PC carried down the pipe
//   flush, redirect_pc       mispredict squash and correct next PC
//   mispredict_count         saturating mispredict counter
module branch_target_predictor #(
  parameter int         INDEX_W  = 3,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetch_pc,
  output logic        pred_hit,
  output logic        spec_taken,
  output logic [15:0] pred_next_pc,
  input  logic        upd_valid,
  input  logic        upd_is_branch,
  input  logic [15:0] upd_pc,
  input  logic        upd_taken,
  input  logic [15:0] upd_target,
  input  logic        upd_spec_taken,
  input  logic [15:0] upd_pred_next,
  output logic        flush,
  output logic [15:0] redirect_pc,
  output logic [15:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 16 - INDEX_W;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [15:0]       target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [INDEX_W-1:0] fidx;
  logic [TAG_W-1:0]   ftag;
  logic [INDEX_W-1:0] ui;
  logic [TAG_W-1:0]   ut;
  logic               upd_hit;
  logic [15:0]        upd_seq;
  logic [15:0]        actual_next;

  // upd_spec_taken is implied by upd_pred_next; the comparison on the full
  // next PC already covers direction errors.
  logic unused_spec;
  assign unused_spec = upd_spec_taken;

  // Lookup reads registered state only, so a same-cycle update to the same
  // index is not visible until the following cycle.
  always_comb begin
    fidx         = fetch_pc[INDEX_W-1:0];
    ftag         = fetch_pc[15:INDEX_W];
    pred_hit     = ~rst & valid_q[fidx] & (tag_q[fidx] == ftag);
    spec_taken   = pred_hit & ctr_q[fidx][1];
    pred_next_pc = spec_taken ? target_q[fidx] : fetch_pc + 16'd1;
  end

  always_comb begin
    ui          = upd_pc[INDEX_W-1:0];
    ut          = upd_pc[15:INDEX_W];
    upd_hit     = valid_q[ui] & (tag_q[ui] == ut);
    upd_seq     = upd_pc + 16'd1;
    // A non-branch always falls through, whatever upd_taken says.
    actual_next = (upd_is_branch & upd_taken) ? upd_target : upd_seq;
    flush       = ~rst & upd_valid & (upd_pred_next != actual_next);
    redirect_pc = flush ? actual_next : upd_seq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
      mispredict_count <= '0;
    end else begin
      if (flush && mispredict_count != 16'hFFFF) begin
        mispredict_count <= mispredict_count + 16'd1;
      end
      if (upd_valid) begin
        if (upd_is_branch) begin
          if (upd_hit) begin
            if (upd_taken) begin
              target_q[ui] <= upd_target;
              if (ctr_q[ui] != 2'd3) ctr_q[ui] <= ctr_q[ui] + 2'd1;
            end else if (ctr_q[ui] != 2'd0) begin
              ctr_q[ui] <= ctr_q[ui] - 2'd1;
            end
          end else if (upd_taken) begin
            // Allocation replaces whatever aliased entry held this index.
            valid_q[ui]  <= 1'b1;
            tag_q[ui]    <= ut;
            target_q[ui] <= upd_target;
            ctr_q[ui]    <= CTR_INIT;
          end
        end else if (upd_hit) begin
          valid_q[ui] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed self-checking bench for branch_target_predictor
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        pred_hit;
  logic        spec_taken;
  logic [15:0] pred_next_pc;
  logic        upd_valid;
  logic        upd_is_branch;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_spec_taken;
  logic [15:0] upd_pred_next;
  logic        flush;
  logic [15:0] redirect_pc;
  logic [15:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  branch_target_predictor #(.INDEX_W(3), .CTR_INIT(2'b10)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .spec_taken(spec_taken), .pred_next_pc(pred_next_pc),
    .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_spec_taken(upd_spec_taken), .upd_pred_next(upd_pred_next),
    .flush(flush), .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic v, input logic br, input logic [15:0] pc,
                     input logic tk, input logic [15:0] tgt, input logic [15:0] pn);
    upd_valid      = v;
    upd_is_branch  = br;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_pred_next  = pn;
    upd_spec_taken = (pn != pc + 16'd1);
    #1;
  endtask

  task automatic idle();
    upd(1'b0, 1'b1, 16'h0012, 1'b1, 16'h0077, 16'h0099);
  endtask

  task automatic look(input string tag, input logic [15:0] pc, input logic hit,
                      input logic sp, input logic [15:0] nxt);
    fetch_pc = pc;
    #1;
    chk({tag, "_hit"}, {15'd0, pred_hit}, {15'd0, hit});
    chk({tag, "_spec"}, {15'd0, spec_taken}, {15'd0, sp});
    chk({tag, "_next"}, pred_next_pc, nxt);
  endtask

  initial begin
    rst = 1'b1;
    fetch_pc = 16'h0010;
    // Reset with a mispredicting update present: no flush, no write.
    upd(1'b1, 1'b1, 16'h0012, 1'b1, 16'h0040, 16'h0013);
    chk("rst_flush", {15'd0, flush}, 16'd0);
    look("rst_look", 16'h0010, 1'b0, 1'b0, 16'h0011);
    tick();
    tick();
    rst = 1'b0;
    idle();
    chk("cold_count", mispredict_count, 16'd0);
    chk("idle_flush", {15'd0, flush}, 16'd0);
    look("cold", 16'h0010, 1'b0, 1'b0, 16'h0011);
    look("cold12", 16'h0012, 1'b0, 1'b0, 16'h0013);

    // Allocate 0x12 -> 0x40; same-cycle lookup sees old (empty) entry.
    upd(1'b1, 1'b1, 16'h0012, 1'b1, 16'h0040, 16'h0013);
    chk("alloc_flush", {15'd0, flush}, 16'd1);
    chk("alloc_redir", redirect_pc, 16'h0040);
    look("collide", 16'h0012, 1'b0, 1'b0, 16'h0013);
    tick();
    idle();
    chk("alloc_count", mispredict_count, 16'd1);
    look("alloc", 16'h0012, 1'b1, 1'b1, 16'h0040);

    // Not taken: ctr 2->1, mispredict.
    upd(1'b1, 1'b1, 16'h0012, 1'b0, 16'h0040, 16'h0040);
    chk("nt1_flush", {15'd0, flush}, 16'd1);
    chk("nt1_redir", redirect_pc, 16'h0013);
    tick();
    idle();
    look("nt1", 16'h0012, 1'b1, 1'b0, 16'h0013);
    // Not taken again: ctr 1->0, predicted correctly.
    upd(1'b1, 1'b1, 16'h0012, 1'b0, 16'h0040, 16'h0013);
    chk("nt2_flush", {15'd0, flush}, 16'd0);
    tick();
    idle();
    chk("nt2_count", mispredict_count, 16'd2);
    look("nt2", 16'h0012, 1'b1, 1'b0, 16'h0013);
    // Two taken: ctr 0->1->2.
    upd(1'b1, 1'b1, 16'h0012, 1'b1, 16'h0040, 16'h0013);
    chk("t1_flush", {15'd0, flush}, 16'd1);
    tick();
    idle();
    look("t1", 16'h0012, 1'b1, 1'b0, 16'h0013);
    upd(1'b1, 1'b1, 16'h0012, 1'b1, 16'h0040, 16'h0013);
    tick();
    idle();
    chk("t2_count", mispredict_count, 16'd4);
    look("t2", 16'h0012, 1'b1, 1'b1, 16'h0040);

    // Five correctly predicted taken updates: ctr saturates at 3.
    for (int i = 0; i < 5; i++) begin
      upd(1'b1, 1'b1, 16'h0012, 1'b1, 16'h0040, 16'h0040);
      chk("sat_flush", {15'd0, flush}, 16'd0);
      tick();
      idle();
      look("sat", 16'h0012, 1'b1, 1'b1, 16'h0040);
    end
    chk("sat_count", mispredict_count, 16'd4);
    // One not-taken from 3 leaves ctr=2, still predicting taken.
    upd(1'b1, 1'b1, 16'h0012, 1'b0, 16'h0040, 16'h0040);
    tick();
    idle();
    look("sat_dec", 16'h0012, 1'b1, 1'b1, 16'h0040);
    chk("sat_dec_count", mispredict_count, 16'd5);

    // Target change on hit.
    upd(1'b1, 1'b1, 16'h0012, 1'b1, 16'h0050, 16'h0040);
    chk("tgt_flush", {15'd0, flush}, 16'd1);
    chk("tgt_redir", redirect_pc, 16'h0050);
    tick();
    idle();
    look("tgt", 16'h0012, 1'b1, 1'b1, 16'h0050);

    // Alias 0x1A replaces 0x12 at index 2.
    upd(1'b1, 1'b1, 16'h001A, 1'b1, 16'h0060, 16'h001B);
    chk("alias_redir", redirect_pc, 16'h0060);
    tick();
    idle();
    chk("alias_count", mispredict_count, 16'd7);
    look("alias_old", 16'h0012, 1'b0, 1'b0, 16'h0013);
    look("alias_new", 16'h001A, 1'b1, 1'b1, 16'h0060);

    // Re-allocate 0x12, then a non-branch at 0x12 predicted taken.
    upd(1'b1, 1'b1, 16'h0012, 1'b1, 16'h0040, 16'h0013);
    tick();
    idle();
    look("realloc", 16'h0012, 1'b1, 1'b1, 16'h0040);
    upd(1'b1, 1'b0, 16'h0012, 1'b1, 16'h0040, 16'h0040);
    chk("nb_flush", {15'd0, flush}, 16'd1);
    chk("nb_redir", redirect_pc, 16'h0013);
    tick();
    idle();
    chk("nb_count", mispredict_count, 16'd9);
    look("nb_inval", 16'h0012, 1'b0, 1'b0, 16'h0013);

    // Correct non-branch and not-taken miss: no flush, no allocation.
    upd(1'b1, 1'b0, 16'h0030, 1'b1, 16'h0099, 16'h0031);
    chk("nb_ok_flush", {15'd0, flush}, 16'd0);
    upd(1'b1, 1'b1, 16'h0025, 1'b0, 16'h0099, 16'h0026);
    chk("ntmiss_flush", {15'd0, flush}, 16'd0);
    tick();
    idle();
    look("ntmiss", 16'h0025, 1'b0, 1'b0, 16'h0026);

    // Wrap of the sequential PC.
    look("wrap", 16'hFFFF, 1'b0, 1'b0, 16'h0000);
    upd(1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'h0000);
    chk("wrap_flush", {15'd0, flush}, 16'd0);
    chk("wrap_redir", redirect_pc, 16'h0000);

    // Mid-stream reset drops a pending update and clears everything.
    upd(1'b1, 1'b1, 16'h0012, 1'b1, 16'h0040, 16'h0013);
    tick();
    idle();
    look("pre_rst", 16'h0012, 1'b1, 1'b1, 16'h0040);
    rst = 1'b1;
    upd(1'b1, 1'b1, 16'h0014, 1'b1, 16'h0070, 16'h0015);
    chk("mrst_flush", {15'd0, flush}, 16'd0);
    look("mrst_look", 16'h0012, 1'b0, 1'b0, 16'h0013);
    tick();
    rst = 1'b0;
    idle();
    chk("mrst_count", mispredict_count, 16'd0);
    look("mrst_12", 16'h0012, 1'b0, 1'b0, 16'h0013);
    look("mrst_14", 16'h0014, 1'b0, 1'b0, 16'h0015);

    // Counter saturation: continuous mispredicts on a not-taken miss.
    upd(1'b1, 1'b1, 16'h0012, 1'b0, 16'h0040, 16'h0040);
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    chk("cnt_fffe", mispredict_count, 16'hFFFE);
    tick();
    chk("cnt_ffff", mispredict_count, 16'hFFFF);
    chk("cnt_flush", {15'd0, flush}, 16'd1);
    tick();
    chk("cnt_sat", mispredict_count, 16'hFFFF);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Fetch-side branch predictor that produces the speculative-taken bit and predicted next PC consumed by the IF/ID pipeline register (spec_taken, pc_next). It is a direct-mapped branch target buffer with per-entry 2-bit saturating counters. It is trained from the execute stage when a branch resolves. On a misprediction it raises a same-cycle flush and redirect for the fetch and decode stages.

## Interface
Parameters:
- INDEX_W, 3: log2 of table entries (8 entries); tag width = 16 - INDEX_W
- CTR_INIT, 2'b10: counter value written on allocation (weakly taken)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_pc  in  16  PC of instruction currently being fetched
- pred_hit  out  1  valid entry with matching tag for fetch_pc
- spec_taken  out  1  predicted taken; goes to IF/ID spec_taken input
- pred_next_pc  out  16  predicted next PC; goes to PC mux and IF/ID pc_next input
- upd_valid  in  1  execute stage holds a valid, non-squashed instruction this cycle
- upd_is_branch  in  1  that instruction is a conditional branch or jump
- upd_pc  in  16  its PC
- upd_taken  in  1  resolved direction
- upd_target  in  16  resolved taken target
- upd_spec_taken  in  1  spec_taken carried down the pipe with it
- upd_pred_next  in  16  pred_next_pc carried down the pipe with it
- flush  out  1  mispredict; squash IF/ID and ID/EX this cycle
- redirect_pc  out  16  correct next PC, valid when flush=1
- mispredict_count  out  16  saturating count of mispredicts

## Operation
- Table entry: valid (1), tag (16-INDEX_W), target (16), ctr (2).
- Lookup (combinational):
  - idx = fetch_pc[INDEX_W-1:0]; tag = fetch_pc[15:INDEX_W].
  - pred_hit = valid[idx] & (tag[idx] == tag).
  - spec_taken = pred_hit & ctr[idx][1].
  - pred_next_pc = spec_taken ? target[idx] : fetch_pc + 1. The addition is 16-bit and wraps: 16'hFFFF + 1 = 16'h0000.
- Correct next PC: actual_next = upd_taken ? upd_target : upd_pc + 1. For a non-branch, actual_next = upd_pc + 1.
- Mispredict (combinational), asserted when upd_valid=1 and upd_pred_next != actual_next. Covers direction errors, target errors, and a predicted-taken non-branch.
  - flush = mispredict; redirect_pc = actual_next. When flush=0, redirect_pc = upd_pc + 1 (don't-care).
- Update, at posedge while upd_valid=1 and rst=0. ui/ut are the index/tag of upd_pc.
  - Branch, hit: ctr saturating +1 if taken, -1 if not taken (limits 0 and 3). On taken, target <= upd_target.
  - Branch, miss, taken: allocate, overwriting any prior entry. valid=1, tag=ut, target=upd_target, ctr=CTR_INIT.
  - Branch, miss, not taken: no change.
  - Non-branch that hits: valid <= 0.
- mispredict_count increments by 1 on each cycle with flush=1 and saturates at 16'hFFFF.

## Timing
- Lookup has zero latency; outputs follow fetch_pc in the same cycle.
- flush and redirect_pc are combinational, in the same cycle as the resolving upd_* inputs.
- Table writes take effect at the next posedge.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update contents. There is no bypass.
- Reset:
  - All valid bits clear, all ctr and target cleared, mispredict_count = 0.
  - While rst=1: pred_hit=0, spec_taken=0, pred_next_pc = fetch_pc+1, flush=0, and no updates occur.
  - Resets mid-stream drop any in-flight update.
- upd_valid=0 means no update and flush=0, regardless of the other upd_* values.

## Test plan
- Reset then cold lookup:
  - After rst, fetch_pc=16'h0010 -> pred_hit=0, spec_taken=0, pred_next_pc=16'h0011.
- Allocate, then train to not-taken:
  - Update pc=16'h0012, branch, taken, target=16'h0040, spec_taken=0, pred_next=16'h0013 -> flush=1, redirect_pc=16'h0040, count=1.
  - Next cycle, fetch_pc=16'h0012 -> pred_hit=1, spec_taken=1, pred_next_pc=16'h0040.
  - Two not-taken updates of 16'h0012 -> ctr 2→1→0 and spec_taken=0. Two taken updates -> ctr=2, spec_taken=1.
- Saturation:
  - Five taken updates on a hit -> ctr stays 3 and flush=0 when predictions match.
  - Counter value 16'hFFFF with a further mispredict -> stays 16'hFFFF.
- Aliasing/replacement:
  - Allocate 16'h0012, then a taken update of 16'h001A (same index, different tag) -> lookup of 16'h0012 misses and lookup of 16'h001A hits.
- Non-branch predicted taken:
  - upd_is_branch=0, upd_pc=16'h0012, upd_pred_next=16'h0040 -> flush=1, redirect_pc=16'h0013, and the entry is invalidated.
- Same-cycle collision and reset:
  - Update and lookup of 16'h0012 in the same cycle -> lookup returns old data.
  - rst asserted with upd_valid=1 -> flush=0, table unchanged-to-cleared, count=0.
- Wrap:
  - fetch_pc=16'hFFFF, miss -> pred_next_pc=16'h0000.
